// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I control unit: sequences IF/ID/EX/MEM/WB over a shared
// memory with a request/ready handshake, plus halt, timeout, illegal-opcode
// detection and a retired-instruction counter.
module mc_control_fsm #(
   parameter int unsigned MEM_TIMEOUT = 0,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [6:0]       opcode,
   input  logic             bcond,
   input  logic             mem_ready,
   input  logic             halt_req,
   output logic             mem_read,
   output logic             mem_write,
   output logic             i_or_d,
   output logic             ir_write,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic             pc_source,
   output logic             reg_write,
   output logic [1:0]       wb_sel,
   output logic [1:0]       alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic             is_halted,
   output logic             mem_err,
   output logic             illegal,
   output logic [CNT_W-1:0] retired
);

   localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LD    = 7'b0000011;
   localparam logic [6:0] OP_ST    = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_ECALL = 7'b1110011;

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EX   = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_HALT = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0]  retired_q, retired_d;
   logic              is_halted_q, is_halted_d;
   logic              mem_err_q, mem_err_d;

   logic is_ld, is_st, is_ecall, is_known, timeout_hit;

   // bcond is applied by the datapath through pc_write_cond; not needed here
   logic unused_bcond;
   assign unused_bcond = bcond;

   assign is_halted = is_halted_q;
   assign mem_err   = mem_err_q;
   assign retired   = retired_q;

   // Opcode class decode and memory-wait timeout detection
   always_comb begin
      is_ld       = (opcode == OP_LD);
      is_st       = (opcode == OP_ST);
      is_ecall    = (opcode == OP_ECALL);
      is_known    = (opcode == OP_R)  || (opcode == OP_I)   || is_ld || is_st ||
                    (opcode == OP_BR) || (opcode == OP_JAL) || (opcode == OP_JALR) || is_ecall;
      // this cycle is the MEM_TIMEOUT-th without ready; a late ready still wins
      timeout_hit = (MEM_TIMEOUT != 0) && !mem_ready &&
                    (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1));
   end

   // State register, wait counter, retired counter and sticky flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IF;
         wait_cnt_q  <= '0;
         retired_q   <= '0;
         is_halted_q <= 1'b0;
         mem_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         retired_q   <= retired_d;
         is_halted_q <= is_halted_d;
         mem_err_q   <= mem_err_d;
      end
   end

   // Next state and control outputs; outputs follow state and handshake inputs
   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = '0;
      retired_d     = retired_q;
      is_halted_d   = is_halted_q;
      mem_err_d     = mem_err_q;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      i_or_d        = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_source     = 1'b0;
      reg_write     = 1'b0;
      wb_sel        = 2'd0;
      alu_src_a     = 2'd0;
      alu_src_b     = 2'd0;
      alu_op        = 2'd0;
      illegal       = 1'b0;

      case (state_q)
         S_IF: begin
            mem_read  = 1'b1;
            alu_src_b = 2'd2;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_ID;
            end else if (timeout_hit) begin
               mem_err_d = 1'b1;
               state_d   = S_HALT;
            end
         end
         S_ID: begin
            alu_src_a = 2'd1;
            alu_src_b = 2'd1;
            if (is_ecall) begin
               state_d = halt_req ? S_HALT : S_IF;
            end else if (is_known) begin
               state_d = S_EX;
            end else begin
               illegal = 1'b1;
               state_d = S_IF;
            end
         end
         S_EX: begin
            state_d = S_IF;
            case (opcode)
               OP_R: begin
                  alu_src_a = 2'd2;
                  alu_op    = 2'd1;
                  state_d   = S_WB;
               end
               OP_I: begin
                  alu_src_a = 2'd2;
                  alu_src_b = 2'd1;
                  alu_op    = 2'd1;
                  state_d   = S_WB;
               end
               OP_LD, OP_ST: begin
                  alu_src_a = 2'd2;
                  alu_src_b = 2'd1;
                  state_d   = S_MEM;
               end
               OP_BR: begin
                  alu_src_a     = 2'd2;
                  alu_op        = 2'd2;
                  pc_write_cond = 1'b1;
                  pc_source     = 1'b1;
               end
               OP_JAL: begin
                  reg_write = 1'b1;
                  wb_sel    = 2'd2;
                  pc_write  = 1'b1;
                  pc_source = 1'b1;
               end
               OP_JALR: begin
                  alu_src_a = 2'd2;
                  alu_src_b = 2'd1;
                  reg_write = 1'b1;
                  wb_sel    = 2'd2;
                  pc_write  = 1'b1;
               end
               default: state_d = S_IF;
            endcase
         end
         S_MEM: begin
            i_or_d    = 1'b1;
            mem_read  = is_ld;
            mem_write = is_st;
            if (mem_ready) begin
               state_d = is_ld ? S_WB : S_IF;
            end else if (timeout_hit) begin
               mem_err_d = 1'b1;
               state_d   = S_HALT;
            end
         end
         S_WB: begin
            reg_write = 1'b1;
            wb_sel    = is_ld ? 2'd1 : 2'd0;
            state_d   = S_IF;
         end
         S_HALT: state_d = S_HALT;
         default: state_d = S_IF;
      endcase

      if (state_d == S_HALT) is_halted_d = 1'b1;

      // wait counter runs only while a memory state is held waiting for ready
      if ((MEM_TIMEOUT != 0) && (state_d == state_q) &&
          ((state_q == S_IF) || (state_q == S_MEM))) begin
         wait_cnt_d = wait_cnt_q + WAIT_W'(1);
      end

      // an instruction retires whenever control returns to IF, except on illegal
      if ((state_d == S_IF) && !illegal &&
          ((state_q == S_ID) || (state_q == S_EX) || (state_q == S_MEM) || (state_q == S_WB))) begin
         retired_d = retired_q + CNT_W'(1);
      end

      // reset aborts any access at once: no request or enable leaks out
      if (reset) begin
         mem_read      = 1'b0;
         mem_write     = 1'b0;
         ir_write      = 1'b0;
         pc_write      = 1'b0;
         pc_write_cond = 1'b0;
         reg_write     = 1'b0;
         illegal       = 1'b0;
      end
   end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: instruction-level reference model
// expands each instruction into its expected per-cycle control vectors.
module tb_mc_control_fsm;

   localparam int unsigned TO = 4;

   logic        clk;
   logic        reset;
   logic [6:0]  opcode;
   logic        bcond, mem_ready, halt_req;
   logic        mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond;
   logic        pc_source, reg_write, is_halted, mem_err, illegal;
   logic [1:0]  wb_sel, alu_src_a, alu_src_b, alu_op;
   logic [31:0] retired;

   mc_control_fsm #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .bcond(bcond),
      .mem_ready(mem_ready), .halt_req(halt_req),
      .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
      .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
      .pc_source(pc_source), .reg_write(reg_write), .wb_sel(wb_sel),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .is_halted(is_halted), .mem_err(mem_err), .illegal(illegal),
      .retired(retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef enum int {K_R, K_I, K_LD, K_ST, K_BR, K_JAL, K_JALR, K_EC, K_ILL, K_ECH} kind_t;

   typedef struct {
      logic        rst;
      logic        rdy;
      logic [6:0]  opc;
      logic        hreq;
      logic        bc;
      logic [16:0] ctrl;
      logic [16:0] mask;
      logic        halted;
      logic        err;
      logic [31:0] ret;
      string       tag;
   } cyc_t;

   cyc_t stim_q[$];
   cyc_t sb_q[$];

   int          errors = 0;
   int          checks = 0;
   logic [31:0] m_ret  = 0;
   logic        m_halt = 1'b0;
   logic        m_err  = 1'b0;

   function automatic logic [16:0] ctl(input logic mr, mw, iod, irw, pcw, pcc, pcs, rw,
                                       input logic [1:0] wb, a, b, op, input logic ill);
      return {mr, mw, iod, irw, pcw, pcc, pcs, rw, wb, a, b, op, ill};
   endfunction

   function automatic logic [6:0] opc_of(input kind_t k);
      case (k)
         K_R:          return 7'b0110011;
         K_I:          return 7'b0010011;
         K_LD:         return 7'b0000011;
         K_ST:         return 7'b0100011;
         K_BR:         return 7'b1100011;
         K_JAL:        return 7'b1101111;
         K_JALR:       return 7'b1100111;
         K_EC, K_ECH:  return 7'b1110011;
         default:      return 7'b0000000;
      endcase
   endfunction

   // queue one cycle; expected counters/flags are the values visible during it
   task automatic push(input logic rst, input logic rdy, input logic [6:0] opc,
                       input logic hreq, input logic [16:0] c, input string tag);
      cyc_t e;
      e.rst    = rst;
      e.rdy    = rdy;
      e.opc    = opc;
      e.hreq   = hreq;
      e.bc     = 1'($urandom);
      e.ctrl   = c;
      e.mask   = rst ? ctl(1, 1, 0, 1, 1, 1, 0, 1, 2'd0, 2'd0, 2'd0, 2'd0, 1) : '1;
      e.halted = m_halt;
      e.err    = m_err;
      e.ret    = m_ret;
      e.tag    = tag;
      stim_q.push_back(e);
   endtask

   task automatic do_reset();
      m_ret  = 0;
      m_halt = 1'b0;
      m_err  = 1'b0;
      push(1'b1, 1'($urandom), 7'($urandom), 1'($urandom), '0, "reset");
   endtask

   task automatic halt_cycles(input int n);
      for (int i = 0; i < n; i++)
         push(1'b0, 1'($urandom), 7'($urandom), 1'($urandom), '0, "halt");
   endtask

   // expand one instruction; abort_at >= 0 resets during that MEM wait cycle
   task automatic gen(input kind_t k, input int ifw, input int memw, input int abort_at);
      logic [6:0]  op;
      logic [16:0] mc;
      logic        is_ld;
      op    = opc_of(k);
      is_ld = (k == K_LD);
      for (int i = 0; i < ifw && i < TO; i++)
         push(1'b0, 1'b0, 7'($urandom), 1'($urandom), ctl(1,0,0,0,0,0,0,0,0,0,2,0,0), "if_wait");
      if (ifw >= TO) begin
         m_halt = 1'b1;
         m_err  = 1'b1;
         return;
      end
      push(1'b0, 1'b1, op, 1'($urandom), ctl(1,0,0,1,1,0,0,0,0,0,2,0,0), "if_ready");
      push(1'b0, 1'($urandom), op, (k == K_ECH) ? 1'b1 : (k == K_EC) ? 1'b0 : 1'($urandom),
           ctl(0,0,0,0,0,0,0,0,0,1,1,0,(k == K_ILL)), "id");
      case (k)
         K_ECH: begin m_halt = 1'b1; return; end
         K_EC:  begin m_ret++; return; end
         K_ILL: return;
         default: ;
      endcase
      case (k)
         K_R:    push(0, 1'($urandom), op, 1'($urandom), ctl(0,0,0,0,0,0,0,0,0,2,0,1,0), "ex_r");
         K_I:    push(0, 1'($urandom), op, 1'($urandom), ctl(0,0,0,0,0,0,0,0,0,2,1,1,0), "ex_i");
         K_BR:   push(0, 1'($urandom), op, 1'($urandom), ctl(0,0,0,0,0,1,1,0,0,2,0,2,0), "ex_br");
         K_JAL:  push(0, 1'($urandom), op, 1'($urandom), ctl(0,0,0,0,1,0,1,1,2,0,0,0,0), "ex_jal");
         K_JALR: push(0, 1'($urandom), op, 1'($urandom), ctl(0,0,0,0,1,0,0,1,2,2,1,0,0), "ex_jalr");
         default: push(0, 1'($urandom), op, 1'($urandom), ctl(0,0,0,0,0,0,0,0,0,2,1,0,0), "ex_mem");
      endcase
      if (k == K_BR || k == K_JAL || k == K_JALR) begin
         m_ret++;
         return;
      end
      if (k == K_LD || k == K_ST) begin
         mc = ctl(is_ld, !is_ld, 1, 0,0,0,0,0, 0,0,0,0, 0);
         for (int i = 0; i < memw && i < TO; i++) begin
            if (i == abort_at) begin
               do_reset();
               return;
            end
            push(1'b0, 1'b0, op, 1'($urandom), mc, "mem_wait");
         end
         if (memw >= TO) begin
            m_halt = 1'b1;
            m_err  = 1'b1;
            return;
         end
         push(1'b0, 1'b1, op, 1'($urandom), mc, "mem_ready");
         if (k == K_ST) begin
            m_ret++;
            return;
         end
      end
      push(0, 1'($urandom), op, 1'($urandom), ctl(0,0,0,0,0,0,0,1, is_ld ? 2'd1 : 2'd0, 0,0,0,0), "wb");
      m_ret++;
   endtask

   // stimulus: build the program, then drive one queued cycle per clock
   initial begin
      cyc_t e;
      reset     = 1'b1;
      opcode    = '0;
      bcond     = 1'b0;
      mem_ready = 1'b0;
      halt_req  = 1'b0;

      do_reset();
      gen(K_R, 0, 0, -1);
      gen(K_ECH, 0, 0, -1);
      halt_cycles(3);
      do_reset();
      gen(K_LD, 0, 3, -1);
      gen(K_BR, 1, 0, -1);
      gen(K_BR, 0, 0, -1);
      gen(K_JAL, 2, 0, -1);
      gen(K_JALR, 0, 0, -1);
      gen(K_I, 0, 0, -1);
      gen(K_ST, 0, 1, -1);
      gen(K_EC, 0, 0, -1);
      gen(K_ILL, 0, 0, -1);
      gen(K_R, 3, 0, -1);
      gen(K_R, 4, 0, -1);
      halt_cycles(3);
      do_reset();
      gen(K_I, 0, 0, -1);
      gen(K_ST, 0, 5, 2);
      gen(K_LD, 1, 2, -1);
      gen(K_ST, 0, 4, -1);
      halt_cycles(2);
      do_reset();
      for (int n = 0; n < 40; n++)
         gen(kind_t'($urandom_range(0, 8)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), -1);
      gen(K_ECH, 0, 0, -1);
      halt_cycles(3);

      while (stim_q.size() > 0) begin
         @(posedge clk);
         #1;
         e         = stim_q.pop_front();
         reset     = e.rst;
         mem_ready = e.rdy;
         opcode    = e.opc;
         halt_req  = e.hreq;
         bcond     = e.bc;
         sb_q.push_back(e);
      end
      for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
      #2;
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected cycles never checked, required 0", sb_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // monitor: compare DUT outputs against the queued expectation each cycle
   initial begin
      cyc_t        e;
      logic [16:0] got;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            got = {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond,
                   pc_source, reg_write, wb_sel, alu_src_a, alu_src_b, alu_op, illegal};
            checks++;
            if (((got ^ e.ctrl) & e.mask) != 17'd0) begin
               errors++;
               $display("FAIL ctrl[%s] t=%0t got=%b required=%b mask=%b", e.tag, $time, got, e.ctrl, e.mask);
            end
            checks++;
            if (retired !== e.ret) begin
               errors++;
               $display("FAIL retired[%s] t=%0t got=%0d required=%0d", e.tag, $time, retired, e.ret);
            end
            checks++;
            if ({is_halted, mem_err} !== {e.halted, e.err}) begin
               errors++;
               $display("FAIL flags[%s] t=%0t got halted=%b err=%b required halted=%b err=%b",
                        e.tag, $time, is_halted, mem_err, e.halted, e.err);
            end
         end
      end
   end

endmodule
